skinny_sbox8_layer_isw1_seq: RTL and testbench

SKINNY_SBOX8_LAYER_ISW1_SEQ -- requirements
Module: skinny_sbox8_layer_isw1_seq

---
 rtl/skinny_sbox8_layer_isw1_seq.sv | 116 +++++++++++
 tb/tb_skinny_sbox8_layer_isw1_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/skinny_sbox8_layer_isw1_seq.sv
// Byte-serial SKINNY sbox8 layer on a 2-share state, driving one external masked sbox8.
// Latency 16*SBOX_LAT cycles from start accept to done; start is ignored while busy.
module skinny_sbox8_layer_isw1_seq #(
    parameter int SBOX_LAT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] si0,
    input  logic [127:0] si1,
    input  logic [15:0]  rnd,
    output logic         rnd_req,
    output logic         busy,
    output logic         done,
    output logic [127:0] so0,
    output logic [127:0] so1,
    output logic [7:0]   sb_si0,
    output logic [7:0]   sb_si1,
    output logic [15:0]  sb_r,
    input  logic [7:0]   sb_bo0,
    input  logic [7:0]   sb_bo1
);

    localparam int CW = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SBOX_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        i_q;
    logic [3:0]        i_nx;
    logic [CW-1:0]     cnt_q;
    logic [15:0][7:0]  sh0_q;
    logic [15:0][7:0]  sh1_q;
    logic              accept;
    logic              capture;
    logic              last;

    assign i_nx = i_q + 4'd1;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    capture = 1'b1;
                    if (i_q == 4'd15) begin
                        last    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One fresh mask per byte: on accept and on every capture except the last.
    assign rnd_req = !rst && (accept || (capture && !last));
    assign busy    = (state_q == RUN);
    assign so0     = sh0_q;
    assign so1     = sh1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= 4'd0;
            cnt_q   <= '0;
            done    <= 1'b0;
            sb_si0  <= 8'd0;
            sb_si1  <= 8'd0;
            sb_r    <= 16'd0;
            sh0_q   <= '0;
            sh1_q   <= '0;
        end else begin
            state_q <= state_d;
            done    <= last;
            if (accept) begin
                sh0_q  <= si0;
                sh1_q  <= si1;
                sb_si0 <= si0[7:0];
                sb_si1 <= si1[7:0];
                sb_r   <= rnd;
                i_q    <= 4'd0;
                cnt_q  <= '0;
            end else if (state_q == RUN) begin
                if (capture) begin
                    // Byte i+1 is still the original input; only byte i is overwritten here.
                    sh0_q[i_q] <= sb_bo0;
                    sh1_q[i_q] <= sb_bo1;
                    cnt_q      <= '0;
                    if (!last) begin
                        i_q    <= i_nx;
                        sb_si0 <= sh0_q[i_nx];
                        sb_si1 <= sh1_q[i_nx];
                        sb_r   <= rnd;
                    end
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_skinny_sbox8_layer_isw1_seq.sv
// Bench for skinny_sbox8_layer_isw1_seq with a behavioural masked sbox8 that only
// presents a correct result once its inputs have been stable for SBOX_LAT cycles.
module tb_skinny_sbox8_layer_isw1_seq;

    localparam int LAT = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] si0 = '0;
    logic [127:0] si1 = '0;
    logic [15:0]  rnd = 16'h1234;
    logic         rnd_req, busy, done;
    logic [127:0] so0, so1;
    logic [7:0]   sb_si0, sb_si1;
    logic [15:0]  sb_r;
    logic [7:0]   sb_bo0, sb_bo1;

    always #5 clk = ~clk;

    skinny_sbox8_layer_isw1_seq #(.SBOX_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .si0(si0), .si1(si1), .rnd(rnd),
        .rnd_req(rnd_req), .busy(busy), .done(done), .so0(so0), .so1(so1),
        .sb_si0(sb_si0), .sb_si1(sb_si1), .sb_r(sb_r),
        .sb_bo0(sb_bo0), .sb_bo1(sb_bo1)
    );

    function automatic logic [7:0] s8(input logic [7:0] v);
        logic [7:0] x;
        x = v;
        for (int r = 0; r < 3; r++) begin
            x = ((~(((x >> 1) | x) >> 2)) & 8'h11) ^ x;
            x = ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
                ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
        end
        x = ((~(((x >> 1) | x) >> 2)) & 8'h11) ^ x;
        return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
    endfunction

    function automatic logic [127:0] sbox_layer(input logic [127:0] x);
        logic [127:0] y;
        for (int k = 0; k < 16; k++) y[k*8 +: 8] = s8(x[k*8 +: 8]);
        return y;
    endfunction

    // External masked sbox: wrong output until inputs have settled LAT cycles.
    int          age = 0;
    logic [31:0] age_prev = '0;
    logic [7:0]  sb_good, sb_mask;
    initial forever begin
        @(negedge clk);
        if ({sb_si0, sb_si1, sb_r} != age_prev) begin
            age_prev = {sb_si0, sb_si1, sb_r};
            age = 1;
        end else if (age < 1000) begin
            age++;
        end
    end
    assign sb_mask = sb_r[7:0] ^ sb_r[15:8];
    assign sb_good = s8(sb_si0 ^ sb_si1) ^ sb_mask;
    assign sb_bo0  = (age >= LAT) ? sb_good : (sb_good ^ 8'h5A);
    assign sb_bo1  = sb_mask;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [127:0] y;
        int           acc;
    } exp_t;
    exp_t exp_q[$];

    int           cyc = 0;
    bit           mon_en = 1'b0;
    bit           req_q = 1'b0;
    logic [31:0]  prev_sb = '0;
    bit           prev_ok = 1'b1;
    bit           pend = 1'b0;
    logic [15:0]  pend_r = '0;
    int           pend_idx = 0;
    int           req_cnt = 0;
    logic [127:0] cur_x = '0;
    int           n_acc = 0, n_done = 0, acc_cyc_last = 0, acc_cyc_prev = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Upstream PRNG: advance after every edge on which rnd was consumed.
    initial forever begin
        @(posedge clk);
        if (req_q) begin
            #1;
            rnd = rnd + 16'h9E37;
        end
    end

    // Monitor: scoreboard, mask/operand checks and input stability.
    initial forever begin
        @(negedge clk);
        req_q = rnd_req;
        if (!mon_en) begin
            prev_sb = {sb_si0, sb_si1, sb_r};
            prev_ok = 1'b1;
        end else begin
            if ({sb_si0, sb_si1, sb_r} != prev_sb)
                chk("sb_change_allowed", 128'(prev_ok), 128'd1);
            if (pend) begin
                chk("sb_r_load", sb_r, pend_r);
                chk("sb_in_byte", sb_si0 ^ sb_si1, cur_x[pend_idx*8 +: 8]);
                pend = 1'b0;
            end
            if (rst) begin
                exp_q.delete();
                req_cnt = 0;
            end
            if (done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL done_unexpected: got done=1 expected no done at cycle %0d", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_time", 128'(cyc), 128'(e.acc + 128));
                    chk("so_xor", so0 ^ so1, e.y);
                    chk("rnd_req_count", 128'(req_cnt), 128'd16);
                end
            end
            if (start && !busy && !rst) begin
                exp_t e;
                e.y = sbox_layer(si0 ^ si1);
                e.acc = cyc + 1;
                exp_q.push_back(e);
                cur_x = si0 ^ si1;
                req_cnt = 0;
                n_acc++;
                acc_cyc_prev = acc_cyc_last;
                acc_cyc_last = cyc + 1;
            end
            if (rnd_req) begin
                pend = 1'b1;
                pend_r = rnd;
                pend_idx = req_cnt;
                req_cnt++;
            end
            prev_sb = {sb_si0, sb_si1, sb_r};
            prev_ok = rnd_req || rst;
        end
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_op(input logic [127:0] a, input logic [127:0] b);
        @(posedge clk);
        #1;
        si0 = a;
        si1 = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) break;
        end
        chk("idle_reached", {busy, exp_q.size() != 0}, 128'd0);
    endtask

    initial begin
        logic [127:0] a, b;
        int a0, nd;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rnd_req", rnd_req, 0);
        chk("rst_sb_in", {sb_si0, sb_si1, sb_r}, 0);
        chk("rst_so", {so0, so1}, 0);

        // All-zero state: S(0x00) = 0x65.
        run_op('0, '0);
        wait_idle();
        chk("zero_state", so0 ^ so1, {16{8'h65}});

        // All-ones state, unshared then randomly shared: S(0xFF) = 0xFF.
        run_op({16{8'hFF}}, '0);
        wait_idle();
        chk("ones_plain", so0 ^ so1, {16{8'hFF}});
        a = rand128();
        run_op(a ^ {16{8'hFF}}, a);
        wait_idle();
        chk("ones_shared", so0 ^ so1, {16{8'hFF}});

        for (int t = 0; t < 3; t++) begin
            a = rand128();
            b = rand128();
            run_op(a, b);
            wait_idle();
            chk("random_golden", so0 ^ so1, sbox_layer(a ^ b));
        end

        // Start held high for 201 edges: accepted at E and again in the done cycle.
        @(posedge clk);
        #1;
        si0 = rand128();
        si1 = rand128();
        a0 = n_acc;
        start = 1'b1;
        repeat (201) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        chk("held_start_accepts", 128'(n_acc - a0), 128'd2);
        chk("held_start_gap", 128'(acc_cyc_last - acc_cyc_prev), 128'd129);

        // Reset with start mid-operation discards the state.
        run_op(rand128(), rand128());
        nd = n_done;
        repeat (49) @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sb_in", {sb_si0, sb_si1, sb_r}, 0);
        chk("mid_rst_so", {so0, so1}, 0);
        rst = 1'b0;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        chk("mid_rst_no_done", 128'(n_done - nd), 128'd0);
        a = rand128();
        b = rand128();
        run_op(a, b);
        wait_idle();
        chk("after_rst_golden", so0 ^ so1, sbox_layer(a ^ b));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
